// File: rtl/bank_mapper.sv
// Bank-register and indirect-bank sequencer that lets a 6502-class core drive
// the upper address lines of a 6509-style banked system.
module bank_mapper #(
    parameter int unsigned BANK_WIDTH   = 8,
    parameter int unsigned LEGACY_WIDTH = 4,
    parameter logic [15:0] REG_BASE     = 16'h0000,
    parameter int unsigned RESET_BANK   = 15,
    parameter logic [7:0]  OPC_MASK     = 8'hDF,
    parameter logic [7:0]  OPC_MATCH    = 8'h91,
    parameter int unsigned IND_START    = 4
) (
    input  logic                  phi2_6509,
    input  logic                  _reset,
    input  logic                  r_w,
    input  logic                  _rdy,
    input  logic                  sync,
    input  logic [15:0]           address_6502,
    input  logic [7:0]            data_6502,
    output logic [BANK_WIDTH-1:0] address_bank,
    output logic                  reg_sel,
    output logic [7:0]            reg_rdata,
    output logic                  flag_full,
    output logic                  ind_active
);

    typedef enum logic [1:0] {IDLE, S55, SAA, S00} unlock_e;

    localparam logic [BANK_WIDTH-1:0] RESET_VAL   = BANK_WIDTH'(RESET_BANK);
    localparam logic [2:0]            IND_START_C = 3'(IND_START);
    localparam logic [2:0]            CTR_MAX     = 3'd7;

    logic [BANK_WIDTH-1:0] exec_bank_q, exec_bank_d;
    logic [BANK_WIDTH-1:0] ind_bank_q, ind_bank_d;
    logic [2:0]            ctr_q, ctr_d;
    unlock_e               state_q, state_d;
    logic                  flag_full_q, flag_full_d;

    logic [BANK_WIDTH-1:0] wdata;
    logic [BANK_WIDTH-1:0] visible_mask;
    logic [BANK_WIDTH-1:0] rd_masked;
    logic                  wr_exec;
    logic                  wr_ind;

    assign reg_sel    = (address_6502[15:1] == REG_BASE[15:1]);
    assign wr_exec    = reg_sel && !r_w && !address_6502[0];
    assign wr_ind     = reg_sel && !r_w && address_6502[0];
    assign ind_active = (ctr_q >= IND_START_C) && !sync;
    assign flag_full  = flag_full_q;

    // Width adaptation: zero-fill writes wider than a byte, hide upper bank
    // bits until full-width banking is unlocked, pad/truncate readback to 8.
    always_comb begin
        wdata        = '0;
        visible_mask = '0;
        reg_rdata    = '0;
        for (int i = 0; i < BANK_WIDTH; i++) begin
            wdata[i]        = (i < 8) ? data_6502[i % 8] : 1'b0;
            visible_mask[i] = flag_full_q || (i < LEGACY_WIDTH);
        end
        rd_masked    = (address_6502[0] ? ind_bank_q : exec_bank_q) & visible_mask;
        address_bank = (ind_active ? ind_bank_q : exec_bank_q) & visible_mask;
        for (int i = 0; i < 8; i++) begin
            reg_rdata[i] = (i < BANK_WIDTH) ? rd_masked[i % BANK_WIDTH] : 1'b0;
        end
    end

    // NOTE: every *_d gets a default before any branch so no path leaves it
    // unassigned; a missed branch in always_comb would otherwise infer a latch.
    always_comb begin
        exec_bank_d = exec_bank_q;
        ind_bank_d  = ind_bank_q;
        ctr_d       = ctr_q;
        state_d     = state_q;
        flag_full_d = flag_full_q;

        if (wr_exec) exec_bank_d = wdata;
        if (wr_ind)  ind_bank_d  = wdata;

        // A stretched cycle freezes the sequencer; the opcode is re-sampled
        // when _rdy returns, so a fresh match always restarts at 1.
        if (_rdy) begin
            if (sync) begin
                ctr_d = ((data_6502 & OPC_MASK) == OPC_MATCH) ? 3'd1 : 3'd0;
            end else if (ctr_q != 3'd0 && ctr_q != CTR_MAX) begin
                ctr_d = ctr_q + 3'd1;
            end
        end

        if (wr_ind) begin
            unique case (state_q)
                IDLE: state_d = (data_6502 == 8'h55) ? S55 : IDLE;
                S55:  state_d = (data_6502 == 8'hAA) ? SAA : IDLE;
                SAA:  state_d = (data_6502 == 8'h00) ? S00 : IDLE;
                S00: begin
                    flag_full_d = data_6502[0];
                    state_d     = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge phi2_6509 or negedge _reset) begin
        if (!_reset) begin
            exec_bank_q <= RESET_VAL;
            ind_bank_q  <= RESET_VAL;
            ctr_q       <= 3'd0;
            state_q     <= IDLE;
            flag_full_q <= 1'b0;
        end else begin
            exec_bank_q <= exec_bank_d;
            ind_bank_q  <= ind_bank_d;
            ctr_q       <= ctr_d;
            state_q     <= state_d;
            flag_full_q <= flag_full_d;
        end
    end

endmodule

// File: tb/tb_bank_mapper.sv
// Self-checking bench for bank_mapper: table-driven per-cycle vectors whose
// expectations are queued at drive time and compared on the falling edge.
module tb_bank_mapper;

    typedef struct {
        logic        r_w;
        logic        rdy;
        logic        sync;
        logic [15:0] addr;
        logic [7:0]  data;
        logic [7:0]  e_bank;
        logic        e_ind;
        logic        e_sel;
        logic        e_full;
        logic [7:0]  e_rdata;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        r_w;
    logic        rdy;
    logic        sync;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [7:0]  address_bank;
    logic        reg_sel;
    logic [7:0]  reg_rdata;
    logic        flag_full;
    logic        ind_active;

    int   n_cmp = 0;
    int   n_err = 0;
    int   n_vec = 0;
    vec_t exp_q[$];
    vec_t vecs[$];

    bank_mapper dut (
        .phi2_6509   (clk),
        ._reset      (rst_n),
        .r_w         (r_w),
        ._rdy        (rdy),
        .sync        (sync),
        .address_6502(addr),
        .data_6502   (data),
        .address_bank(address_bank),
        .reg_sel     (reg_sel),
        .reg_rdata   (reg_rdata),
        .flag_full   (flag_full),
        .ind_active  (ind_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic w_r, input logic w_rdy, input logic w_sync,
                                input logic [15:0] a, input logic [7:0] d,
                                input logic [7:0] eb, input logic ei, input logic ef,
                                input logic [7:0] er);
        vec_t v;
        v.r_w = w_r; v.rdy = w_rdy; v.sync = w_sync; v.addr = a; v.data = d;
        v.e_bank = eb; v.e_ind = ei; v.e_full = ef; v.e_rdata = er;
        v.e_sel = (a[15:1] == 15'h0);
        return v;
    endfunction

    task automatic apply(input vec_t v);
        @(posedge clk);
        #1;
        r_w = v.r_w; rdy = v.rdy; sync = v.sync; addr = v.addr; data = v.data;
        exp_q.push_back(v);
    endtask

    always @(negedge clk) begin : scoreboard
        vec_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check($sformatf("v%0d address_bank", n_vec), 32'(address_bank), 32'(e.e_bank));
            check($sformatf("v%0d ind_active", n_vec), 32'(ind_active), 32'(e.e_ind));
            check($sformatf("v%0d reg_sel", n_vec), 32'(reg_sel), 32'(e.e_sel));
            check($sformatf("v%0d flag_full", n_vec), 32'(flag_full), 32'(e.e_full));
            if (e.e_sel && e.r_w)
                check($sformatf("v%0d reg_rdata", n_vec), 32'(reg_rdata), 32'(e.e_rdata));
            n_vec++;
        end
    end

    initial begin
        rst_n = 1'b1; r_w = 1'b1; rdy = 1'b1; sync = 1'b0; addr = 16'h2000; data = 8'h00;
        #1 rst_n = 1'b0;
        #1;
        check("reset address_bank", 32'(address_bank), 32'h0F);
        check("reset ind_active", 32'(ind_active), 32'h0);
        check("reset flag_full", 32'(flag_full), 32'h0);
        #1 rst_n = 1'b1;

        // Register access, legacy masking and a plain LDA (zp),Y sequence.
        vecs.push_back(mk(1,1,0,16'h0000,8'h00,8'h0F,0,0,8'h0F));
        vecs.push_back(mk(1,1,0,16'h0001,8'h00,8'h0F,0,0,8'h0F));
        vecs.push_back(mk(0,1,0,16'h0000,8'h3A,8'h0F,0,0,8'h00));
        vecs.push_back(mk(1,1,1,16'hC000,8'hEA,8'h0A,0,0,8'h00));
        vecs.push_back(mk(1,1,0,16'h0000,8'h00,8'h0A,0,0,8'h0A));
        vecs.push_back(mk(0,1,0,16'h0001,8'h05,8'h0A,0,0,8'h00));
        vecs.push_back(mk(1,1,0,16'h0001,8'h00,8'h0A,0,0,8'h05));
        vecs.push_back(mk(1,1,1,16'hC001,8'hB1,8'h0A,0,0,8'h00));
        vecs.push_back(mk(1,1,0,16'hC002,8'h20,8'h0A,0,0,8'h00));
        vecs.push_back(mk(1,1,0,16'h0020,8'h34,8'h0A,0,0,8'h00));
        vecs.push_back(mk(1,1,0,16'h0021,8'h12,8'h0A,0,0,8'h00));
        vecs.push_back(mk(1,1,0,16'h1234,8'h00,8'h05,1,0,8'h00));
        vecs.push_back(mk(1,1,0,16'h1334,8'h00,8'h05,1,0,8'h00));
        vecs.push_back(mk(1,1,1,16'hC003,8'hEA,8'h0A,0,0,8'h00));
        vecs.push_back(mk(1,1,0,16'h2000,8'h00,8'h0A,0,0,8'h00));
        // Three stretched clocks in cycle 2 push the switch out by three.
        vecs.push_back(mk(1,1,1,16'hC004,8'hB1,8'h0A,0,0,8'h00));
        vecs.push_back(mk(1,1,0,16'hC005,8'h20,8'h0A,0,0,8'h00));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1,0,0,16'h0020,8'h34,8'h0A,0,0,8'h00));
        vecs.push_back(mk(1,1,0,16'h0020,8'h34,8'h0A,0,0,8'h00));
        vecs.push_back(mk(1,1,0,16'h0021,8'h12,8'h0A,0,0,8'h00));
        vecs.push_back(mk(1,1,0,16'h1234,8'h00,8'h05,1,0,8'h00));
        // Stretched opcode fetch: counter must hold, not clear.
        vecs.push_back(mk(1,0,1,16'hC006,8'hEA,8'h0A,0,0,8'h00));
        vecs.push_back(mk(1,1,0,16'h1334,8'h00,8'h05,1,0,8'h00));
        vecs.push_back(mk(1,1,1,16'hC006,8'hEA,8'h0A,0,0,8'h00));
        vecs.push_back(mk(1,1,0,16'h2000,8'h00,8'h0A,0,0,8'h00));
        // Saturation at 7, then a matching opcode restarts the count at 1.
        vecs.push_back(mk(1,1,1,16'hC010,8'hB1,8'h0A,0,0,8'h00));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(1,1,0,16'h3000,8'h00,(i >= 3) ? 8'h05 : 8'h0A,(i >= 3),0,8'h00));
        vecs.push_back(mk(1,1,1,16'hC011,8'hB1,8'h0A,0,0,8'h00));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1,1,0,16'h3000,8'h00,(i == 3) ? 8'h05 : 8'h0A,(i == 3),0,8'h00));
        // STA (zp),Y matches; ORA (zp),Y does not.
        vecs.push_back(mk(1,1,1,16'hC020,8'h91,8'h0A,0,0,8'h00));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0,1,0,16'h3000,8'h00,(i == 3) ? 8'h05 : 8'h0A,(i == 3),0,8'h00));
        vecs.push_back(mk(1,1,1,16'hC021,8'h11,8'h0A,0,0,8'h00));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(1,1,0,16'h3000,8'h00,8'h0A,0,0,8'h00));
        vecs.push_back(mk(1,1,1,16'hC022,8'hEA,8'h0A,0,0,8'h00));

        foreach (vecs[i]) apply(vecs[i]);

        // Unlock sequence with an unrelated write interleaved.
        apply(mk(0,1,0,16'h0001,8'h55,8'h0A,0,0,8'h00));
        apply(mk(0,1,0,16'h2000,8'h77,8'h0A,0,0,8'h00));
        apply(mk(0,1,0,16'h0001,8'hAA,8'h0A,0,0,8'h00));
        apply(mk(0,1,0,16'h0001,8'h00,8'h0A,0,0,8'h00));
        apply(mk(0,1,0,16'h0001,8'h01,8'h0A,0,0,8'h00));
        apply(mk(0,1,0,16'h0000,8'hC7,8'h3A,0,1,8'h00));
        apply(mk(1,1,0,16'h0000,8'h00,8'hC7,0,1,8'hC7));
        apply(mk(1,1,0,16'h0001,8'h00,8'hC7,0,1,8'h01));
        // Broken sequence must drop to IDLE, so the trailing AA,00,00 is inert.
        apply(mk(0,1,0,16'h0001,8'h55,8'hC7,0,1,8'h00));
        apply(mk(0,1,0,16'h0001,8'hAB,8'hC7,0,1,8'h00));
        apply(mk(0,1,0,16'h0001,8'hAA,8'hC7,0,1,8'h00));
        apply(mk(0,1,0,16'h0001,8'h00,8'hC7,0,1,8'h00));
        apply(mk(0,1,0,16'h0001,8'h00,8'hC7,0,1,8'h00));
        apply(mk(1,1,0,16'h2000,8'h00,8'hC7,0,1,8'h00));

        // Asynchronous reset with FSM in SAA and the counter at 3.
        apply(mk(0,1,0,16'h0001,8'h55,8'hC7,0,1,8'h00));
        apply(mk(0,1,0,16'h0001,8'hAA,8'hC7,0,1,8'h00));
        apply(mk(1,1,1,16'hC030,8'hB1,8'hC7,0,1,8'h00));
        apply(mk(1,1,0,16'hC031,8'h20,8'hC7,0,1,8'h00));
        apply(mk(1,1,0,16'h0020,8'h34,8'hC7,0,1,8'h00));
        apply(mk(1,1,0,16'h0021,8'h12,8'hC7,0,1,8'h00));
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async reset ind_active", 32'(ind_active), 32'h0);
        check("async reset flag_full", 32'(flag_full), 32'h0);
        check("async reset address_bank", 32'(address_bank), 32'h0F);
        #1 rst_n = 1'b1;
        apply(mk(0,1,0,16'h0001,8'h00,8'h0F,0,0,8'h00));
        apply(mk(0,1,0,16'h0001,8'h01,8'h0F,0,0,8'h00));
        apply(mk(1,1,0,16'h0001,8'h00,8'h0F,0,0,8'h01));
        apply(mk(1,1,0,16'h0000,8'h00,8'h0F,0,0,8'h0F));

        @(negedge clk);
        #1;
        check("scoreboard drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bank_mapper.md
# bank_mapper

Parametrised bank-register and indirect-bank sequencer that lets a plain 6502-class core drive the upper address lines of a banked (6509-style) system. It holds the execution and indirect bank registers at two memory-mapped locations, detects the indirect-indexed opcodes and switches the upper address bus to the indirect bank for those operand cycles. It gates full-width banking behind a write-unlock sequence. It sits between the CPU address/data pins and the system bus, in place of the fixed 4-bit bank logic.

## Interface
- BANK_WIDTH, 8: width of bank registers and of `address_bank`.
- LEGACY_WIDTH, 4: bank bits visible while `flag_full`=0; upper bits forced to 0.
- REG_BASE, 16'h0000: address of execution bank register; indirect register at REG_BASE+1; REG_BASE[0] must be 0.
- RESET_BANK, 15: reset value of both bank registers (BANK_WIDTH bits).
- OPC_MASK, 8'hDF: opcode bits compared for indirect detection.
- OPC_MATCH, 8'h91: masked opcode value triggering indirect sequencing; defaults select $91 STA (zp),Y and $B1 LDA (zp),Y.
- IND_START, 4: cycle index after the opcode fetch at which the indirect bank is first driven; legal 2..7.

Ports:
- phi2_6509  in  1  system clock; all state updates on rising edge.
- _reset  in  1  asynchronous, active-low reset.
- r_w  in  1  CPU read(1)/write(0).
- _rdy  in  1  1 = cycle completes; 0 = stretched cycle.
- sync  in  1  opcode-fetch cycle marker from CPU.
- address_6502  in  16  CPU address.
- data_6502  in  8  CPU data bus (write data or fetched opcode).
- address_bank  out  BANK_WIDTH  upper system address.
- reg_sel  out  1  current cycle addresses a bank register; system must not drive data.
- reg_rdata  out  8  bank-register readback, valid when reg_sel & r_w.
- flag_full  out  1  full-width banking enabled.
- ind_active  out  1  indirect bank currently selected.

## Operation
- reg_sel = address_6502[15:1] == REG_BASE[15:1]. Write (r_w=0, reg_sel) on the rising edge loads the execution register (addr[0]=0) or the indirect register (addr[0]=1) with data_6502[BANK_WIDTH-1:0]. Upper bits are zero-filled if BANK_WIDTH>8. Writes ignore _rdy.
- reg_rdata = selected register, bits ≥ LEGACY_WIDTH zeroed when flag_full=0, truncated/zero-padded to 8.
- Indirect detect: on an edge with sync=1, _rdy=1 and (data_6502 & OPC_MASK)==OPC_MATCH, set seq counter to 1. Otherwise, on any edge with sync=1 and _rdy=1, clear the counter to 0. While nonzero, each edge with _rdy=1 increments it, saturating at 7.
- ind_active = (ctr ≥ IND_START) & !sync. It drops combinationally on the next opcode fetch.
- address_bank = ind_active ? indirect reg : execution reg. Bits ≥ LEGACY_WIDTH are forced 0 unless flag_full.
- Unlock FSM (states IDLE, S55, SAA, S00) advances only on writes to REG_BASE+1:
  - IDLE→S55 on $55; stays in IDLE otherwise.
  - S55→SAA on $AA; else →IDLE.
  - SAA→S00 on $00; else →IDLE.
  - S00: flag_full ← data[0], then →IDLE.
- Sequence writes also load the indirect register as normal writes. Writes elsewhere do not disturb the FSM.
- Reset: both registers = RESET_BANK, ctr=0, FSM=IDLE, flag_full=0. Outputs are address_bank = RESET_BANK masked (8'h0F at defaults), ind_active=0, reg_sel combinational.

## Timing
- Register, counter, FSM and flag updates take effect immediately after the rising phi2 edge. address_bank reflects a bank write from the next cycle on.
- A write to the execution register during the cycle it is used does not alter address_bank for that cycle.
- With _rdy=0 the counter holds and a sync-cycle opcode is not sampled. The same cycle re-evaluates when _rdy returns.
- Simultaneous matching opcode and counter at 7: the counter restarts at 1.
- Reset is asserted asynchronously at any point (mid-sequence, mid-unlock). All state returns to reset values with no clock needed. Deassertion is synchronous to the design.
- Combinational paths: address/sync/data → reg_sel, reg_rdata, ind_active, address_bank. No added register latency.

## Test plan
- Reset, then read $0000 and $0001 → reg_rdata=8'h0F; address_bank=8'h0F; flag_full=0.
- Write $3A to $0000, fetch NOP → address_bank=8'h0A from the next cycle (upper nibble masked).
- Write $05 to $0001, then LDA ($20),Y ($B1) with _rdy=1 → address_bank=execution bank on cycles 0–3 and 8'h05 on cycle 4. On a page-cross it stays 8'h05 on cycle 5. Execution bank returns at the next sync.
- Same sequence with _rdy=0 held 3 clocks in cycle 2 → indirect switch delayed by exactly 3 clocks.
- Write $55,$AA,$00,$01 to $0001, then $C7 to $0000 → flag_full=1, address_bank=8'hC7. Repeat with $55,$AB → flag_full is unchanged and the FSM returns to IDLE.
- Assert _reset mid-sequence at counter=3 and FSM=SAA → ind_active=0, flag_full=0, and address_bank=8'h0F immediately.
